servo_ramp_sequencer: RTL and testbench
=======================================

Name: servo_ramp_sequencer

Overview:
Slew-rate-limited position scheduler for a bank of NCH servo PWM channels, each an 8-bit position plus a move-enable.
- Accepts per-channel target commands over a valid/ready handshake.
- Once per servo frame, sweeps all channels and steps each current position toward its target by at most STEP.
- Drives each PWM generator's position input and move-enable, so joints move smoothly instead of jumping.

Parameters:
NCH, 4, number of servo channels (2..8)
UPDATE_DIV, 240000, clk cycles per ramp frame (20 ms at 12 MHz)
STEP, 4, max position change per channel per frame (1..255)
HOME, 127, position loaded into every channel at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_ch  in  3  target channel index
cmd_pos  in  8  target position 0..255
enable  in  1  global move enable
pos_out  out  8*NCH  current positions; channel k at bits [8k+7:8k]
en_out  out  NCH  per-channel move-enable to the PWM blocks
busy  out  1  any channel still ramping
done  out  1  one-cycle pulse when all channels reach target

Behaviour:
- Reset (rst=1 at a clk edge), including mid-sweep:
  - cur[k]=tgt[k]=HOME; en_reg=0; frame counter=0; state=IDLE.
  - pos_out all HOME; en_out=0; busy=0; done=0; cmd_ready=1.
- Frame counter counts 0..UPDATE_DIV-1 and wraps. tick=1 for the one cycle the counter equals UPDATE_DIV-1. The counter runs in every state.
- Handshake:
  - Transfer occurs when cmd_valid&cmd_ready.
  - Next cycle: tgt[cmd_ch]<=cmd_pos and en_reg[cmd_ch]<=1.
  - If cmd_ch>=NCH, the command is acknowledged and discarded, with no state change.
  - cmd_ready=0 only in SWEEP; 1 otherwise.
- FSM:
  - IDLE: busy=0. Go to RUN when any cur!=tgt. A command with cmd_pos==cur stays IDLE and produces no done.
  - RUN: busy=1. Go to SWEEP on tick.
  - SWEEP: busy=1, exactly NCH cycles. Index i=0..NCH-1 updates one channel per cycle:
    - cur<tgt: cur<=min(cur+STEP,tgt).
    - cur>tgt: cur<=max(cur-STEP,tgt).
    - Compute in 9 bits; the result never wraps past 0 or 255.
    - After i=NCH-1: if all cur==tgt, then done=1 for one cycle and go to IDLE; else go to RUN.
- Command accepted the same cycle tick fires in RUN: target write completes before SWEEP reads channel 0, so it is used in this sweep.
- enable=0:
  - en_out=0 one cycle later.
  - SWEEP still runs but leaves cur unchanged; commands are still accepted.
  - On return to 1, en_out=en_reg one cycle later and ramping resumes at the next tick.
- pos_out and en_out are registered, with no combinational path from inputs.

Optional Feature:
Macro SERVO_RAMP_AT_TARGET_EN.
- Defined: adds output at_target[NCH-1:0]. Bit k is registered cur[k]==tgt[k], updated the cycle after any cur/tgt change, and is all ones after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use NCH=4, UPDATE_DIV=16, STEP=4, HOME=127.
- Reset check: rst 2 cycles -> pos_out=4x127, en_out=0000, busy=0, cmd_ready=1, done=0.
- Up-ramp with clamp: cmd ch1 pos 137 -> en_out[1]=1; ch1 goes 131, 135, 137 on three successive sweeps; single done pulse after the third sweep; busy then 0.
- Boundaries without wrap:
  - ch0 to 0 -> 32 sweeps, ending ...7, 3, 0, never 252.
  - ch2 to 255 -> 32 sweeps ending 251, 255, never wrapping to 3.
- Backpressure: hold cmd_valid during SWEEP -> cmd_ready low for exactly 4 cycles; command accepted the first cycle after; target used on the next frame.
- Illegal channel and no-op: cmd_ch=5 -> acknowledged, no output change. cmd ch3 pos 127 while IDLE -> stays IDLE, no done.
- Enable and mid-ramp reset: enable=0 during a ramp to 200 -> en_out=0 next cycle, positions frozen across ticks. Re-enable -> ramping resumes. Assert rst mid-SWEEP -> all 127 and IDLE next cycle.

Source files
------------

// File: rtl/servo_ramp_sequencer.sv
// rtl/servo_ramp_sequencer.sv - slew-rate-limited position scheduler for NCH servo PWM channels
//
// Purpose: holds a current and a target 8-bit position per channel. Once per
// ramp frame (UPDATE_DIV clocks) it sweeps the channels, one per cycle, moving
// each current position toward its target by at most STEP.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  command accepted when high (low only while sweeping)
//   cmd_ch     target channel index (indices >= NCH are acknowledged and dropped)
//   cmd_pos    target position
//   enable     global move enable; when low en_out is forced off and positions freeze
//   pos_out    current positions, channel k at [8k+7:8k]
//   en_out     per-channel move-enable
//   busy       some channel is still ramping
//   done       one-cycle pulse when a sweep leaves every channel on target
//   at_target  per-channel cur==tgt flags (only with SERVO_RAMP_AT_TARGET_EN)
//
// Optional feature macro: SERVO_RAMP_AT_TARGET_EN
module servo_ramp_sequencer #(
  parameter int NCH        = 4,
  parameter int UPDATE_DIV = 240000,
  parameter int STEP       = 4,
  parameter int HOME       = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_ch,
  input  logic [7:0]         cmd_pos,
  input  logic               enable,
  output logic [8*NCH-1:0]   pos_out,
  output logic [NCH-1:0]     en_out,
  output logic               busy,
  output logic               done
`ifdef SERVO_RAMP_AT_TARGET_EN
  ,
  output logic [NCH-1:0]     at_target
`endif
);

  localparam int            CW       = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int            IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
  localparam logic [3:0]    NCH_L    = 4'(NCH);
  localparam logic [8:0]    STEP9    = 9'(STEP);
  localparam logic [7:0]    STEP8    = 8'(STEP);
  localparam logic [7:0]    HOME8    = 8'(HOME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SWEEP
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [NCH-1:0][7:0]  r_cur;
  logic [NCH-1:0][7:0]  r_tgt;
  logic [NCH-1:0]       r_en_reg;
  logic [NCH-1:0]       r_en_out;
  logic                 r_done;

  logic                 w_tick;
  logic                 w_xfer;
  logic                 w_legal;
  logic                 w_last;
  logic                 w_any_diff;
  logic                 w_all_eq_after;
  logic [7:0]           w_cur_i;
  logic [7:0]           w_tgt_i;
  logic [7:0]           w_new_i;
  logic [8:0]           w_up;
  logic [8:0]           w_floor;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign cmd_ready = (r_state != S_SWEEP);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pos_out   = r_cur;
  assign en_out    = r_en_out;
  assign w_xfer    = cmd_valid && cmd_ready;
  assign w_legal   = ({1'b0, cmd_ch} < NCH_L);
  assign w_last    = (r_idx == IDX_LAST);

  // Free-running frame counter, independent of the FSM state.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Channel currently addressed by the sweep and its stepped value.
  // Arithmetic is 9 bits wide so the clamp decision never sees a wrapped value.
  assign w_cur_i = r_cur[r_idx];
  assign w_tgt_i = r_tgt[r_idx];
  assign w_up    = {1'b0, w_cur_i} + STEP9;
  // cur - STEP < tgt is rewritten as cur < tgt + STEP to avoid underflow.
  assign w_floor = {1'b0, w_tgt_i} + STEP9;

  always_comb begin
    w_new_i = w_cur_i;
    if (enable) begin
      if (w_cur_i < w_tgt_i) begin
        w_new_i = (w_up >= {1'b0, w_tgt_i}) ? w_tgt_i : w_up[7:0];
      end else if (w_cur_i > w_tgt_i) begin
        w_new_i = ({1'b0, w_cur_i} <= w_floor) ? w_tgt_i : (w_cur_i - STEP8);
      end
    end
  end

  // w_all_eq_after is only meaningful on the last sweep slot: it folds in the
  // value the last channel is about to take.
  always_comb begin
    w_any_diff     = 1'b0;
    w_all_eq_after = (w_new_i == w_tgt_i);
    for (int k = 0; k < NCH; k++) begin
      if (r_cur[k] != r_tgt[k]) begin
        w_any_diff = 1'b1;
        if (k != NCH - 1) begin
          w_all_eq_after = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_diff) w_next = S_RUN;
      S_RUN:   if (w_tick) w_next = S_SWEEP;
      S_SWEEP: if (w_last) w_next = w_all_eq_after ? S_IDLE : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_cur    <= {NCH{HOME8}};
      r_tgt    <= {NCH{HOME8}};
      r_en_reg <= '0;
      r_en_out <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_en_out <= enable ? r_en_reg : '0;
      // A write landing on the tick edge is visible to slot 0 of the sweep.
      if (w_xfer && w_legal) begin
        r_tgt[cmd_ch[IW-1:0]]    <= cmd_pos;
        r_en_reg[cmd_ch[IW-1:0]] <= 1'b1;
      end
      if (r_state == S_SWEEP) begin
        r_cur[r_idx] <= w_new_i;
        r_idx        <= w_last ? '0 : (r_idx + IW'(1));
        if (w_last && w_all_eq_after) begin
          r_done <= 1'b1;
        end
      end else begin
        r_idx <= '0;
      end
    end
  end

`ifdef SERVO_RAMP_AT_TARGET_EN
  logic [NCH-1:0] r_at_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_at_target <= '1;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_at_target[k] <= (r_cur[k] == r_tgt[k]);
      end
    end
  end

  assign at_target = r_at_target;
`endif

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// tb/tb_servo_ramp_sequencer.sv - self-checking bench for servo_ramp_sequencer
`timescale 1ns/1ps
module tb_servo_ramp_sequencer;

  localparam int NCH  = 4;
  localparam int UDIV = 16;
  localparam int STEP = 4;
  localparam int HOME = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_ch = 3'd0;
  logic [7:0]  cmd_pos = 8'd0;
  logic        enable = 1'b1;
  logic        cmd_ready;
  logic [31:0] pos_out;
  logic [3:0]  en_out;
  logic        busy;
  logic        done;
`ifdef SERVO_RAMP_AT_TARGET_EN
  logic [3:0]  at_target;
`endif

  always #5 clk = ~clk;

  servo_ramp_sequencer #(
    .NCH(NCH), .UPDATE_DIV(UDIV), .STEP(STEP), .HOME(HOME)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos),
    .enable(enable),
    .pos_out(pos_out), .en_out(en_out),
    .busy(busy), .done(done)
`ifdef SERVO_RAMP_AT_TARGET_EN
    , .at_target(at_target)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: per-channel current/target/enable and sweep bookkeeping.
  int m_cur[NCH];
  int m_tgt[NCH];
  bit m_en[NCH];
  int sweep_cnt = 0;
  int done_cnt  = 0;
  int low_cnt   = 0;
  bit sweep_en  = 1'b1;

  function automatic int step_to(input int c, input int t);
    if (t > c) return (t - c > STEP) ? c + STEP : t;
    if (t < c) return (c - t > STEP) ? c - STEP : t;
    return c;
  endfunction

  function automatic logic [31:0] pack_cur();
    logic [31:0] v;
    for (int k = 0; k < NCH; k++) v[8*k +: 8] = 8'(m_cur[k]);
    return v;
  endfunction

  function automatic logic [3:0] pack_en();
    logic [3:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_en[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cur[k] = HOME;
      m_tgt[k] = HOME;
      m_en[k]  = 1'b0;
    end
  endtask

  // Advance to the next falling edge and observe the sweep window there.
  // A sweep is the run of cycles with cmd_ready low; at its end the model
  // steps every channel once and the outputs are compared.
  task automatic tick();
    bit all_eq;
    @(negedge clk);
    if (rst) begin
      low_cnt = 0;
    end else if (cmd_ready === 1'b0) begin
      if (low_cnt == 0) sweep_en = enable;
      low_cnt++;
    end else if (low_cnt > 0) begin
      n_total++;
      if (low_cnt != NCH) $display("FAIL sweep_len: got %0d cycles, want %0d", low_cnt, NCH);
      else n_pass++;
      if (sweep_en) for (int k = 0; k < NCH; k++) m_cur[k] = step_to(m_cur[k], m_tgt[k]);
      all_eq = 1'b1;
      for (int k = 0; k < NCH; k++) if (m_cur[k] != m_tgt[k]) all_eq = 1'b0;
      n_total++;
      if (pos_out !== pack_cur()) $display("FAIL sweep_pos: got %h, want %h", pos_out, pack_cur());
      else n_pass++;
      n_total++;
      if (done !== all_eq) $display("FAIL sweep_done: got %b, want %b", done, all_eq);
      else n_pass++;
      n_total++;
      if (busy !== !all_eq) $display("FAIL sweep_busy: got %b, want %b", busy, !all_eq);
      else n_pass++;
      sweep_cnt++;
      low_cnt = 0;
    end else begin
      n_total++;
      if (done !== 1'b0) $display("FAIL done_spurious: got %b, want 0", done);
      else n_pass++;
    end
    if (!rst && done === 1'b1) done_cnt++;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    cmd_valid = 1'b0;
    enable = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input int pos);
    int guard;
    guard = 0;
    tick();
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_pos   = 8'(pos);
    while (cmd_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    n_total++;
    if (guard >= 100) $display("FAIL cmd_accept: cmd_ready stuck at %b, want 1", cmd_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    if (ch < NCH) begin
      m_tgt[ch] = pos;
      m_en[ch]  = 1'b1;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sweeps(input int n);
    int target;
    int guard;
    target = sweep_cnt + n;
    guard  = 0;
    while (sweep_cnt < target && guard < n * UDIV * 3 + 50) begin
      tick();
      guard++;
    end
    n_total++;
    if (sweep_cnt < target) $display("FAIL sweep_timeout: got %0d sweeps, want %0d", sweep_cnt, target);
    else n_pass++;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    repeat (3) tick();
    while (busy !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_total++;
    if (pos_out !== {4{8'd127}}) $display("FAIL reset_pos: got %h, want 7f7f7f7f", pos_out);
    else n_pass++;
    n_total++;
    if (en_out !== 4'b0000) $display("FAIL reset_en: got %b, want 0000", en_out);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset_flags: busy=%b done=%b ready=%b, want 0 0 1", busy, done, cmd_ready);
    else n_pass++;
`ifdef SERVO_RAMP_AT_TARGET_EN
    n_total++;
    if (at_target !== 4'hF) $display("FAIL reset_at_target: got %b, want 1111", at_target);
    else n_pass++;
`endif
  endtask

  task automatic test_up_ramp();
    int d0;
    int exp_seq[3];
    exp_seq = '{131, 135, 137};
    do_reset();
    d0 = done_cnt;
    send(1, 137);
    repeat (3) tick();
    n_total++;
    if (en_out !== 4'b0010) $display("FAIL ramp_en: got %b, want 0010", en_out);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wait_sweeps(1);
      n_total++;
      if (pos_out[15:8] !== 8'(exp_seq[i]))
        $display("FAIL ramp_step%0d: got %0d, want %0d", i, pos_out[15:8], exp_seq[i]);
      else n_pass++;
    end
    n_total++;
    if (done_cnt != d0 + 1) $display("FAIL ramp_done_count: got %0d, want %0d", done_cnt - d0, 1);
    else n_pass++;
    wait_idle();
    repeat (40) tick();
    n_total++;
    if (done_cnt != d0 + 1 || busy !== 1'b0)
      $display("FAIL ramp_settled: done pulses %0d busy %b, want 1 and 0", done_cnt - d0, busy);
    else n_pass++;
`ifdef SERVO_RAMP_AT_TARGET_EN
    n_total++;
    if (at_target !== 4'hF) $display("FAIL ramp_at_target: got %b, want 1111", at_target);
    else n_pass++;
`endif
  endtask

  task automatic test_boundary(input int ch, input int target, input int forbidden, input int penult);
    int n;
    int prev;
    int cur;
    bit hit_bad;
    do_reset();
    send(ch, target);
    n = 0;
    prev = HOME;
    cur = HOME;
    hit_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_sweeps(1);
      n++;
      prev = cur;
      cur = int'(pos_out[8*ch +: 8]);
      if (cur == forbidden) hit_bad = 1'b1;
      if (busy === 1'b0) break;
    end
    n_total++;
    if (hit_bad) $display("FAIL bound_wrap ch%0d: saw %0d, want never", ch, forbidden);
    else n_pass++;
    n_total++;
    if (n != 32) $display("FAIL bound_sweeps ch%0d: got %0d, want 32", ch, n);
    else n_pass++;
    n_total++;
    if (cur != target || prev != penult)
      $display("FAIL bound_end ch%0d: got %0d,%0d want %0d,%0d", ch, prev, cur, penult, target);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int guard;
    int cnt;
    do_reset();
    send(0, 0);
    guard = 0;
    while (cmd_ready !== 1'b0 && guard < 100) begin
      tick();
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_ch    = 3'd1;
    cmd_pos   = 8'd150;
    cnt = (cmd_ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_ready === 1'b0) cnt++;
      else break;
    end
    n_total++;
    if (cnt != NCH) $display("FAIL bp_ready_low: got %0d cycles, want %0d", cnt, NCH);
    else n_pass++;
    @(posedge clk);
    #1;
    m_tgt[1] = 150;
    m_en[1]  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_sweeps(1);
    n_total++;
    if (pos_out[15:8] !== 8'd131) $display("FAIL bp_next_frame: got %0d, want 131", pos_out[15:8]);
    else n_pass++;
  endtask

  task automatic test_illegal_noop();
    logic [31:0] snap_pos;
    logic [3:0]  snap_en;
    int d0;
    bit went_busy;
    do_reset();
    repeat (3) tick();
    snap_pos = pos_out;
    snap_en  = en_out;
    send(5, 33);
    repeat (5) tick();
    n_total++;
    if (pos_out !== snap_pos || en_out !== snap_en || busy !== 1'b0)
      $display("FAIL illegal_ch: pos %h en %b busy %b, want %h %b 0", pos_out, en_out, busy, snap_pos, snap_en);
    else n_pass++;
    d0 = done_cnt;
    send(3, 127);
    went_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0) went_busy = 1'b1;
    end
    n_total++;
    if (went_busy || done_cnt != d0)
      $display("FAIL noop_idle: busy seen %b done pulses %0d, want 0 0", went_busy, done_cnt - d0);
    else n_pass++;
    n_total++;
    if (en_out !== 4'b1000) $display("FAIL noop_en: got %b, want 1000", en_out);
    else n_pass++;
  endtask

  task automatic test_enable_reset();
    logic [31:0] snap;
    int guard;
    do_reset();
    send(1, 200);
    wait_sweeps(1);
    tick();
    enable = 1'b0;
    tick();
    n_total++;
    if (en_out !== 4'b0000) $display("FAIL dis_en_out: got %b, want 0000", en_out);
    else n_pass++;
    snap = pos_out;
    wait_sweeps(2);
    n_total++;
    if (pos_out !== snap || busy !== 1'b1)
      $display("FAIL dis_frozen: pos %h busy %b, want %h 1", pos_out, busy, snap);
    else n_pass++;
    tick();
    enable = 1'b1;
    tick();
    n_total++;
    if (en_out !== 4'b0010) $display("FAIL reen_en_out: got %b, want 0010", en_out);
    else n_pass++;
    wait_sweeps(1);
    n_total++;
    if (pos_out[15:8] !== snap[15:8] + 8'd4)
      $display("FAIL reen_resume: got %0d, want %0d", pos_out[15:8], snap[15:8] + 8'd4);
    else n_pass++;
    guard = 0;
    while (cmd_ready !== 1'b0 && guard < 100) begin
      tick();
      guard++;
    end
    rst = 1'b1;
    model_reset();
    tick();
    n_total++;
    if (pos_out !== {4{8'd127}} || busy !== 1'b0 || cmd_ready !== 1'b1 || en_out !== 4'b0000)
      $display("FAIL midsweep_reset: pos %h busy %b ready %b en %b, want 7f7f7f7f 0 1 0000",
               pos_out, busy, cmd_ready, en_out);
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 30)) tick();
    end
    wait_idle();
    n_total++;
    if (pos_out !== pack_cur()) $display("FAIL rand_final_pos: got %h, want %h", pos_out, pack_cur());
    else n_pass++;
    n_total++;
    if (en_out !== pack_en()) $display("FAIL rand_en: got %b, want %b", en_out, pack_en());
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_ramp();
    test_boundary(0, 0, 252, 3);
    test_boundary(2, 255, 3, 251);
    test_backpressure();
    test_illegal_noop();
    test_enable_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
